// File: rtl/game_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : game_ctrl
// Purpose  : Game timing and control. Produces a one-cycle game tick from a
//            phase accumulator, debounces the jump and pause buttons, encodes
//            the speed/difficulty switches, runs the IDLE/RUN/PAUSE/DEAD
//            state machine and applies an optional automatic speed ramp.
// Revision : 1.0 - initial release
// =============================================================================
module game_ctrl #(
   parameter int ACC_W      = 27,
   parameter int N_SPEED    = 4,
   parameter int N_DIFF     = 4,
   parameter int DIFF_W     = 2,
   parameter int LVL_W      = 4,
   parameter int MAX_LEVEL  = 7,
   parameter int BASE_INC   = 3,
   parameter int STEP_INC   = 2,
   parameter int DB_CYCLES  = 1000000,
   parameter int RAMP_EN    = 1,
   parameter int RAMP_TICKS = 64
) (
   input  logic               CLK100MHZ,
   input  logic               reset_btn,
   input  logic               jump_btn,
   input  logic               pause_btn,
   input  logic [N_SPEED-1:0] speed_in,
   input  logic [N_DIFF-1:0]  difficulty_in,
   input  logic               isdead,
   output logic               tick,
   output logic               jump,
   output logic               start,
   output logic [1:0]         game_state,
   output logic [LVL_W-1:0]   speed_level,
   output logic [DIFF_W-1:0]  difficulty
);

   localparam int C_DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam int C_RC_W = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;

   localparam logic [C_DB_W-1:0] C_DB_LAST = C_DB_W'(DB_CYCLES - 1);
   localparam logic [C_RC_W-1:0] C_RC_LAST = C_RC_W'(RAMP_TICKS - 1);
   localparam logic [LVL_W-1:0]  C_MAX_LVL = LVL_W'(MAX_LEVEL);
   localparam logic [ACC_W-1:0]  C_BASE    = ACC_W'(BASE_INC);
   localparam logic [ACC_W-1:0]  C_STEP    = ACC_W'(STEP_INC);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DEAD  = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic                w_jump_out;

   logic [1:0]          w_raw;
   logic [1:0]          w_press;
   logic                w_jump_stb;
   logic                w_pause_stb;

   logic [LVL_W-1:0]    w_enc_speed;
   logic [DIFF_W-1:0]   w_enc_diff;
   logic [LVL_W-1:0]    r_enc_speed;
   logic [DIFF_W-1:0]   r_enc_diff;

   logic [ACC_W-1:0]    r_acc;
   logic [ACC_W-1:0]    w_inc;
   logic [ACC_W-1:0]    w_sum;
   logic                w_carry;
   logic                w_advance;
   logic                r_tick;

   logic [LVL_W-1:0]    r_speed_level;
   logic [DIFF_W-1:0]   r_difficulty;
   logic [C_RC_W-1:0]   r_ramp_cnt;

   // -------------------------------------------------------------------------
   // Button conditioning: bit 0 is jump, bit 1 is pause.
   // -------------------------------------------------------------------------
   assign w_raw = {pause_btn, jump_btn};

   for (genvar gi = 0; gi < 2; gi++) begin : g_db
      logic              r_s1;
      logic              r_s2;
      logic              r_level;
      logic              r_press;
      logic [C_DB_W-1:0] r_cnt;

      // Synchronise, count consecutive disagreeing samples, flip the level once
      // the window fills, and strobe only on a 0->1 flip.
      always_ff @(posedge CLK100MHZ) begin
         if (reset_btn) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
         end else begin
            r_s1    <= w_raw[gi];
            r_s2    <= r_s1;
            r_press <= 1'b0;
            if (r_s2 == r_level) begin
               r_cnt <= '0;
            end else if (r_cnt == C_DB_LAST) begin
               r_cnt   <= '0;
               r_level <= r_s2;
               r_press <= r_s2;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end

      assign w_press[gi] = r_press;
   end

   assign w_jump_stb  = w_press[0];
   assign w_pause_stb = w_press[1];

   // -------------------------------------------------------------------------
   // Switch encoders
   // -------------------------------------------------------------------------

   // Highest set bit wins; the later loop iterations overwrite earlier ones.
   always_comb begin
      w_enc_speed = '0;
      for (int i = 0; i < N_SPEED; i++) begin
         if (speed_in[i]) w_enc_speed = LVL_W'(i + 1);
      end
      w_enc_diff = '0;
      for (int i = 0; i < N_DIFF; i++) begin
         if (difficulty_in[i]) w_enc_diff = DIFF_W'(i);
      end
   end

   // Register the encoded switches so no input reaches an output directly.
   always_ff @(posedge CLK100MHZ) begin
      if (reset_btn) begin
         r_enc_speed <= '0;
         r_enc_diff  <= '0;
      end else begin
         r_enc_speed <= w_enc_speed;
         r_enc_diff  <= w_enc_diff;
      end
   end

   // -------------------------------------------------------------------------
   // Game state machine
   // -------------------------------------------------------------------------

   // State register.
   always_ff @(posedge CLK100MHZ) begin
      if (reset_btn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state decode and jump pulse gating; death outranks pause in RUN.
   always_comb begin
      w_state_next = r_state;
      w_jump_out   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_jump_out = w_jump_stb;
            if (w_jump_stb) w_state_next = ST_RUN;
         end
         ST_RUN: begin
            w_jump_out = w_jump_stb;
            if (isdead) begin
               w_state_next = ST_DEAD;
            end else if (w_pause_stb) begin
               w_state_next = ST_PAUSE;
            end
         end
         ST_PAUSE: begin
            if (w_pause_stb) w_state_next = ST_RUN;
         end
         ST_DEAD: begin
            if (w_jump_stb) w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Phase accumulator and tick
   // -------------------------------------------------------------------------
   assign w_inc            = C_BASE + C_STEP * ACC_W'(r_speed_level);
   assign {w_carry, w_sum} = {1'b0, r_acc} + {1'b0, w_inc};

   // The accumulator only moves in cycles where RUN continues, so a pause
   // taken on a carry cycle keeps that carry for the resume.
   assign w_advance = (r_state == ST_RUN) && (w_state_next == ST_RUN);

   // Accumulate in RUN, hold in PAUSE/DEAD, clear in IDLE and on entry to it.
   always_ff @(posedge CLK100MHZ) begin
      if (reset_btn) begin
         r_acc  <= '0;
         r_tick <= 1'b0;
      end else begin
         r_tick <= 1'b0;
         if ((r_state == ST_IDLE) || (w_state_next == ST_IDLE)) begin
            r_acc <= '0;
         end else if (w_advance) begin
            r_acc  <= w_sum;
            r_tick <= w_carry;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Speed level, difficulty and ramp
   // -------------------------------------------------------------------------

   // Track the switches in IDLE; otherwise freeze them and step the speed
   // level every RAMP_TICKS ticks up to MAX_LEVEL.
   always_ff @(posedge CLK100MHZ) begin
      if (reset_btn) begin
         r_speed_level <= '0;
         r_difficulty  <= '0;
         r_ramp_cnt    <= '0;
      end else if (r_state == ST_IDLE) begin
         r_speed_level <= r_enc_speed;
         r_difficulty  <= r_enc_diff;
         r_ramp_cnt    <= '0;
      end else if (w_state_next == ST_IDLE) begin
         r_ramp_cnt <= '0;
      end else if ((RAMP_EN != 0) && w_advance && w_carry) begin
         if (r_ramp_cnt == C_RC_LAST) begin
            r_ramp_cnt <= '0;
            if (r_speed_level < C_MAX_LVL) begin
               r_speed_level <= r_speed_level + 1'b1;
            end
         end else begin
            r_ramp_cnt <= r_ramp_cnt + 1'b1;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign tick        = r_tick;
   assign jump        = w_jump_out;
   assign start       = (r_state != ST_IDLE);
   assign game_state  = r_state;
   assign speed_level = r_speed_level;
   assign difficulty  = r_difficulty;

endmodule
`default_nettype wire

// File: tb/tb_game_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : tb_game_ctrl
// Purpose  : Scoreboard bench for game_ctrl. A cycle model built from the
//            game rules predicts every output after each clock edge; a
//            separate monitor pops and compares those predictions.
// Revision : 1.0 - initial release
// =============================================================================
module tb_game_ctrl;

   localparam int DB    = 4;
   localparam int RT    = 2;
   localparam int MAXL  = 3;
   localparam int BASE  = 3;
   localparam int STEP  = 2;
   localparam int WRAP  = 16;

   localparam int S_IDLE  = 0;
   localparam int S_RUN   = 1;
   localparam int S_PAUSE = 2;
   localparam int S_DEAD  = 3;

   logic       CLK100MHZ = 1'b0;
   logic       reset_btn;
   logic       jump_btn;
   logic       pause_btn;
   logic [1:0] speed_in;
   logic [3:0] difficulty_in;
   logic       isdead;
   logic       tick;
   logic       jump;
   logic       start;
   logic [1:0] game_state;
   logic [3:0] speed_level;
   logic [1:0] difficulty;

   typedef struct packed {
      logic       tick;
      logic       jump;
      logic       start;
      logic [1:0] gs;
      logic [3:0] lvl;
      logic [1:0] dif;
   } obs_t;

   obs_t sb_q[$];
   int   n_vec  = 0;
   int   n_bad  = 0;
   int   n_push = 0;

   game_ctrl #(
      .ACC_W      (4),
      .N_SPEED    (2),
      .N_DIFF     (4),
      .DIFF_W     (2),
      .LVL_W      (4),
      .MAX_LEVEL  (MAXL),
      .BASE_INC   (BASE),
      .STEP_INC   (STEP),
      .DB_CYCLES  (DB),
      .RAMP_EN    (1),
      .RAMP_TICKS (RT)
   ) dut (
      .CLK100MHZ     (CLK100MHZ),
      .reset_btn     (reset_btn),
      .jump_btn      (jump_btn),
      .pause_btn     (pause_btn),
      .speed_in      (speed_in),
      .difficulty_in (difficulty_in),
      .isdead        (isdead),
      .tick          (tick),
      .jump          (jump),
      .start         (start),
      .game_state    (game_state),
      .speed_level   (speed_level),
      .difficulty    (difficulty)
   );

   always #5 CLK100MHZ = ~CLK100MHZ;

   // ---------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------
   int m_state, m_total, m_ticks, m_start, m_lvl, m_dif, m_enc_spd, m_enc_dif;
   bit m_press [2];
   int m_db    [2];
   int hist_q  [2][$];   // raw samples still travelling through the synchroniser
   int win_q   [2][$];   // synchronised samples seen since the last level flip

   function automatic int msb_idx(int v);
      int r;
      r = -1;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return r;
   endfunction

   // Predict the outputs that follow the coming clock edge.
   task automatic model_edge(output obs_t e);
      int raw [2];
      int nxt, old, smp;
      bit new_tick, all_diff;
      new_tick = 1'b0;
      raw[0]   = int'(jump_btn);
      raw[1]   = int'(pause_btn);
      if (reset_btn) begin
         m_state   = S_IDLE;
         m_total   = 0;
         m_ticks   = 0;
         m_start   = 0;
         m_lvl     = 0;
         m_dif     = 0;
         m_enc_spd = 0;
         m_enc_dif = 0;
         for (int b = 0; b < 2; b++) begin
            hist_q[b].delete();
            hist_q[b].push_back(0);
            hist_q[b].push_back(0);
            win_q[b].delete();
            m_press[b] = 1'b0;
            m_db[b]    = 0;
         end
      end else begin
         nxt = m_state;
         case (m_state)
            S_IDLE:  if (m_press[0]) nxt = S_RUN;
            S_RUN:   if (isdead) nxt = S_DEAD; else if (m_press[1]) nxt = S_PAUSE;
            S_PAUSE: if (m_press[1]) nxt = S_RUN;
            default: if (m_press[0]) nxt = S_IDLE;
         endcase
         if (m_state == S_IDLE) begin
            m_total = 0;
            m_ticks = 0;
            m_lvl   = m_enc_spd;
            m_start = m_enc_spd;
            m_dif   = m_enc_dif;
         end else if (nxt == S_IDLE) begin
            m_total = 0;
            m_ticks = 0;
         end else if (m_state == S_RUN && nxt == S_RUN) begin
            old     = m_total;
            m_total = m_total + BASE + STEP * m_lvl;
            if ((m_total / WRAP) != (old / WRAP)) begin
               new_tick = 1'b1;
               m_ticks++;
               m_lvl = (m_start + m_ticks / RT > MAXL) ? MAXL : m_start + m_ticks / RT;
            end
         end
         m_enc_spd = msb_idx(int'(speed_in)) + 1;
         m_enc_dif = (difficulty_in == 4'd0) ? 0 : msb_idx(int'(difficulty_in));
         for (int b = 0; b < 2; b++) begin
            smp = hist_q[b].pop_front();
            hist_q[b].push_back(raw[b]);
            win_q[b].push_back(smp);
            if (win_q[b].size() > DB) void'(win_q[b].pop_front());
            m_press[b] = 1'b0;
            if (win_q[b].size() == DB) begin
               all_diff = 1'b1;
               for (int i = 0; i < DB; i++) begin
                  if (win_q[b][i] == m_db[b]) all_diff = 1'b0;
               end
               if (all_diff) begin
                  m_db[b]    = smp;
                  m_press[b] = (smp != 0);
                  win_q[b].delete();
               end
            end
         end
         m_state = nxt;
      end
      e.tick  = new_tick;
      e.jump  = m_press[0] && (m_state == S_IDLE || m_state == S_RUN);
      e.start = (m_state != S_IDLE);
      e.gs    = 2'(m_state);
      e.lvl   = 4'(m_lvl);
      e.dif   = 2'(m_dif);
   endtask

   // ---------------------------------------------------------------------
   // Stimulus helpers
   // ---------------------------------------------------------------------
   task automatic step();
      obs_t e;
      model_edge(e);
      @(posedge CLK100MHZ);
      sb_q.push_back(e);
      n_push++;
      @(negedge CLK100MHZ);
   endtask

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic press(input int b, input int hold, input int rel);
      if (b == 0) jump_btn = 1'b1; else pause_btn = 1'b1;
      cyc(hold);
      if (b == 0) jump_btn = 1'b0; else pause_btn = 1'b0;
      cyc(rel);
   endtask

   // ---------------------------------------------------------------------
   // Monitor: compare every presented output set against the scoreboard
   // ---------------------------------------------------------------------
   obs_t mon_e;
   obs_t mon_a;
   int   mon_cyc = 0;

   always @(negedge CLK100MHZ) begin
      mon_cyc++;
      if (sb_q.size() > 0) begin
         mon_e       = sb_q.pop_front();
         mon_a.tick  = tick;
         mon_a.jump  = jump;
         mon_a.start = start;
         mon_a.gs    = game_state;
         mon_a.lvl   = speed_level;
         mon_a.dif   = difficulty;
         n_vec++;
         if (mon_a !== mon_e) begin
            n_bad++;
            $display("FAIL outputs cyc %0d: got tick=%0b jump=%0b start=%0b state=%0d lvl=%0d diff=%0d, want tick=%0b jump=%0b start=%0b state=%0d lvl=%0d diff=%0d",
                     mon_cyc, mon_a.tick, mon_a.jump, mon_a.start, mon_a.gs, mon_a.lvl, mon_a.dif,
                     mon_e.tick, mon_e.jump, mon_e.start, mon_e.gs, mon_e.lvl, mon_e.dif);
         end
      end
   end

   // ---------------------------------------------------------------------
   // Directed scenarios followed by randomised play
   // ---------------------------------------------------------------------
   initial begin
      reset_btn     = 1'b1;
      jump_btn      = 1'b0;
      pause_btn     = 1'b0;
      isdead        = 1'b0;
      speed_in      = 2'b00;
      difficulty_in = 4'b0000;
      cyc(3);
      reset_btn = 1'b0;

      // Switch encoding in IDLE.
      speed_in      = 2'b11;
      difficulty_in = 4'b0110;
      cyc(4);

      // Short glitch, then a real press that starts the game.
      press(0, 3, 10);
      press(0, 10, 4);

      // Switch changes during RUN must not reach the outputs.
      speed_in      = 2'b00;
      difficulty_in = 4'b0001;
      cyc(30);

      // Pause and resume.
      press(1, 6, 20);
      press(1, 6, 20);

      // Death arriving in the same cycle as a pause strobe.
      pause_btn = 1'b1;
      cyc(6);
      isdead = 1'b1;
      cyc(1);
      isdead = 1'b0;
      cyc(2);
      pause_btn = 1'b0;
      cyc(8);

      // Jump in DEAD returns to IDLE; then a level-0 game long enough to saturate.
      press(0, 8, 6);
      speed_in = 2'b00;
      cyc(3);
      press(0, 8, 80);

      // Reset in RUN while a jump press is being debounced.
      jump_btn = 1'b1;
      cyc(3);
      reset_btn = 1'b1;
      cyc(1);
      reset_btn = 1'b0;
      jump_btn  = 1'b0;
      cyc(12);

      // Randomised play.
      for (int it = 0; it < 400; it++) begin
         int act;
         act = int'($urandom_range(0, 9));
         case (act)
            0, 1, 2: press(0, int'($urandom_range(1, 10)), int'($urandom_range(1, 10)));
            3, 4:    press(1, int'($urandom_range(1, 10)), int'($urandom_range(1, 10)));
            5: begin
               isdead = 1'b1;
               cyc(int'($urandom_range(1, 4)));
               isdead = 1'b0;
            end
            6: begin
               speed_in      = 2'($urandom);
               difficulty_in = 4'($urandom);
               cyc(2);
            end
            7: cyc(int'($urandom_range(5, 40)));
            8: begin
               if ($urandom_range(0, 3) == 0) begin
                  reset_btn = 1'b1;
                  cyc(1);
                  reset_btn = 1'b0;
               end
               cyc(3);
            end
            default: begin
               isdead = 1'b1;
               press(1, 6, 2);
               isdead = 1'b0;
            end
         endcase
      end
      cyc(5);

      #2;
      if (n_vec != n_push) begin
         n_bad++;
         $display("FAIL drain: got %0d compared, want %0d pushed", n_vec, n_push);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
- Parametrised game-timing and control block; the next generation of the top-level clock-divider, start-latch and speed/difficulty encoder logic.
- Generates a single-cycle game tick enable from CLK100MHZ instead of a divided clock. Debounces the jump and pause buttons.
- Runs the IDLE/RUN/PAUSE/DEAD game state machine and applies an optional automatic speed ramp.
- Feeds physics_engine, map_gen, score_engine and display_engine_as. Their clock-enable inputs take tick.

Parameters:
- ACC_W, 27: phase-accumulator width. tick fires on accumulator carry-out.
- N_SPEED, 4: width of speed_in.
- N_DIFF, 4: width of difficulty_in.
- DIFF_W, 2: width of the difficulty output. Must satisfy 2^DIFF_W >= N_DIFF.
- LVL_W, 4: width of the speed-level register.
- MAX_LEVEL, 7: ceiling for the speed ramp. Must satisfy N_SPEED <= MAX_LEVEL <= 2^LVL_W-1.
- BASE_INC, 3: accumulator increment at level 0.
- STEP_INC, 2: additional increment per speed level.
- DB_CYCLES, 1000000: debounce stability window, in clock cycles.
- RAMP_EN, 1: 1 enables the automatic speed ramp in RUN.
- RAMP_TICKS, 64: number of ticks per ramp step.

Ports:
- CLK100MHZ, in, 1: the single system clock. All logic is on its rising edge.
- reset_btn, in, 1: synchronous, active-high reset.
- jump_btn, in, 1: raw jump/start button, asynchronous.
- pause_btn, in, 1: raw pause button, asynchronous.
- speed_in, in, N_SPEED: speed switches, priority-encoded.
- difficulty_in, in, N_DIFF: difficulty switches, priority-encoded.
- isdead, in, 1: death flag from physics_engine.
- tick, out, 1: one-cycle game-rate enable.
- jump, out, 1: one-cycle debounced jump press pulse.
- start, out, 1: high whenever game_state != IDLE.
- game_state, out, 2: 0=IDLE, 1=RUN, 2=PAUSE, 3=DEAD.
- speed_level, out, LVL_W: current speed level.
- difficulty, out, DIFF_W: current difficulty.

Behaviour:
- Reset (reset_btn high at a clock edge):
  - game_state=IDLE; tick=jump=start=0; speed_level=0; difficulty=0.
  - Accumulator, ramp counter, synchronisers and debounce counters are cleared; both buttons read as released.
  - Reset overrides every other event in the same cycle, including mid-RUN and mid-debounce.
- Debounce, per button:
  - Two-flop synchroniser feeds a counter.
  - The debounced level flips only after DB_CYCLES consecutive synchronised samples that differ from it. Any agreeing sample clears the counter.
  - A press is a 0->1 flip of the debounced level, registered as a one-cycle internal strobe.
  - Raw rising edge to strobe latency: DB_CYCLES+2 cycles.
  - Releases produce no strobe.
- Encoders, registered, 1-cycle latency:
  - enc_speed = 1 + index of the highest set bit of speed_in, or 0 if none is set.
  - enc_diff = index of the highest set bit of difficulty_in. Bit 0 alone, or no bits set, gives 0.
- Accumulator:
  - inc = BASE_INC + STEP_INC*speed_level, computed at ACC_W bits.
  - In RUN: acc <= acc + inc modulo 2^ACC_W. tick is registered high on the cycle after an add that carries out.
  - Only RUN produces ticks.
- IDLE:
  - acc=0 and tick=0.
  - speed_level <= enc_speed and difficulty <= enc_diff every cycle.
  - Jump strobe: jump=1 for that cycle and the state goes to RUN.
  - Pause strobe is ignored.
- RUN:
  - speed_level and difficulty are frozen against the switches.
  - Jump strobe: jump=1.
  - isdead=1: go to DEAD. This has priority over a same-cycle pause strobe, and the jump pulse is still emitted that cycle.
  - Otherwise, pause strobe: go to PAUSE.
- PAUSE:
  - acc and the ramp counter are held; tick=0; jump is suppressed.
  - isdead is ignored.
  - Pause strobe: go to RUN, resuming from the held acc value.
- DEAD:
  - tick=0; jump is suppressed.
  - Jump strobe: go to IDLE and clear acc. The switches are re-encoded from the next cycle.
- Speed ramp (RAMP_EN=1, RUN only):
  - The ramp counter increments on each tick.
  - When the counter reaches RAMP_TICKS: counter <= 0, and if speed_level < MAX_LEVEL then speed_level <= speed_level+1.
  - Saturates at MAX_LEVEL.
  - The new inc applies from the next add.
  - The ramp counter clears on entry to IDLE.
- The unused upper bits of inc are zero.
- No combinational path from any input to any output.

Test Plan (ACC_W=4, DB_CYCLES=4, BASE_INC=3, STEP_INC=2, RAMP_TICKS=2, MAX_LEVEL=3, N_SPEED=2):
- Debounce:
  - jump_btn glitches high for 3 cycles -> no jump pulse, state stays IDLE.
  - jump_btn held high for 10 cycles -> exactly one jump pulse, 6 cycles after the rising edge, and state=RUN.
- Encoding in IDLE:
  - speed_in=2'b11, difficulty_in=4'b0110 -> speed_level=2 and difficulty=2 within 2 cycles.
  - Changing the switches during RUN leaves both outputs unchanged.
- Tick rate:
  - RUN at level 0: acc sequence 3,6,9,12,15,2 -> first tick 1 cycle after the 6th add, then a period of 5 or 6 cycles per the carry pattern.
  - Exactly one-cycle-wide pulses.
- Ramp:
  - Start at level 0 -> level becomes 1 after the 2nd tick, 2 after the 4th, 3 after the 6th, and stays at 3 after the 8th.
  - inc sequence is 3,5,7,9.
- Pause and death:
  - Pause press in RUN -> tick stays 0, jump is suppressed and acc is held.
  - Second pause press -> ticks resume with the same phase.
  - isdead and a pause strobe in the same cycle -> state=DEAD.
  - Jump press in DEAD -> IDLE, start=0.
- Reset mid-run:
  - reset_btn asserted in RUN mid-debounce -> next cycle all outputs 0 and state IDLE.
  - No spurious jump pulse after reset is released while jump_btn is held low.
